serial_eq_cmp_amisha: RTL and testbench
=======================================

SERIAL_EQ_CMP_AMISHA -- requirements
Module: serial_eq_cmp_amisha

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8 (legal range 2..32), giving the operand width in bits.
REQ-002 The block SHALL have port clk_amisha  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n_amisha  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start_amisha  input  1  request a compare; sampled only in IDLE.
REQ-005 The block SHALL have port abort_amisha  input  1  cancel an in-progress compare.
REQ-006 The block SHALL have ports a_amisha and b_amisha  input  WIDTH  operands, captured on an accepted start.
REQ-007 The block SHALL have ports i0_amisha and i1_amisha  output  1  the current bit pair fed to the downstream 1-bit equality stage.
REQ-008 The block SHALL have port busy_amisha  output  1  high in SHIFT.
REQ-009 The block SHALL have port done_amisha  output  1  single-cycle completion pulse.
REQ-010 The block SHALL have port eq_amisha  output  1  word-equal result, valid from done until the next accepted start.
REQ-011 The block SHALL have port mismatch_cnt_amisha  output  $clog2(WIDTH+1)  number of differing bit positions.

Function
REQ-012 The block SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start_amisha=1 at edge T, the block SHALL capture a_amisha and b_amisha into shift registers, clear the bit index and counter, and enter SHIFT.
REQ-014 In SHIFT, the block SHALL present one bit pair per cycle, LSB first, on i0_amisha/i1_amisha, at cycles T+1..T+WIDTH.
REQ-015 In SHIFT, the block SHALL increment mismatch_cnt_amisha on each cycle where i0_amisha != i1_amisha; the counter SHALL saturate at WIDTH and never wrap.
REQ-016 After the bit with index WIDTH-1, the block SHALL enter DONE; done_amisha SHALL be 1 for exactly cycle T+WIDTH+1, then the block SHALL return to IDLE.
REQ-017 In DONE, eq_amisha SHALL equal (mismatch_cnt_amisha==0), and both outputs SHALL hold until the next accepted start.
REQ-018 In IDLE and DONE, i0_amisha and i1_amisha SHALL drive 0.
REQ-019 start_amisha asserted in SHIFT or DONE SHALL be ignored, with no queueing; a start in the cycle after DONE SHALL be accepted.
REQ-020 abort_amisha=1 in SHIFT SHALL return the block to IDLE on the next edge with no done pulse, and eq_amisha/mismatch_cnt_amisha SHALL be cleared to 0.
REQ-021 abort_amisha and start_amisha asserted together in IDLE SHALL give priority to abort, so start is not accepted.
REQ-022 Operand changes during SHIFT SHALL NOT affect the result.

Reset
REQ-023 rst_n_amisha=0 SHALL force, asynchronously and at any state including mid-SHIFT: state=IDLE, busy_amisha=0, done_amisha=0, eq_amisha=0, mismatch_cnt_amisha=0, i0_amisha=0, i1_amisha=0, and cleared shift registers.
REQ-024 After reset release, the first rising edge SHALL be able to accept a start.

Configuration
REQ-025 With macro SERIAL_EQ_EARLY_EXIT_EN defined, the first mismatching bit SHALL move SHIFT to DONE on the next edge, so mismatch_cnt_amisha=1 and eq_amisha=0, and done_amisha SHALL pulse at T+k+2, where k is the index of the first mismatching bit.
REQ-026 Without SERIAL_EQ_EARLY_EXIT_EN, all WIDTH bits SHALL always be scanned and the latency SHALL be fixed at WIDTH+1.

Verification
REQ-027 The bench SHALL cover: WIDTH=8, a=b=8'hA5, start -> i0/i1 sequence 1,0,1,0,0,1,0,1; done at T+9; eq=1, cnt=0.
REQ-028 The bench SHALL cover: a=8'hFF, b=8'h00 -> eq=0, cnt=8 (no macro); with the macro, done at T+2, cnt=1.
REQ-029 The bench SHALL cover: a=8'h01, b=8'h81 -> no macro: cnt=1, done at T+9; with the macro: done at T+9 (k=7).
REQ-030 The bench SHALL cover: start re-pulsed at T+3 during SHIFT -> ignored; exactly one done pulse.
REQ-031 The bench SHALL cover: abort at T+4 -> IDLE at T+5, no done pulse, eq=0, cnt=0; a new start at T+6 completes normally.
REQ-032 The bench SHALL cover: rst_n_amisha low at T+3, between clock edges -> all outputs 0 immediately; after release, a compare of 8'h3C vs 8'h3C gives eq=1.

Source files
------------

// File: rtl/serial_eq_cmp_amisha_if.sv
// Handshake, operand and result bundle for the serial equality comparator.
interface serial_eq_cmp_amisha_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic             start_amisha;
    logic             abort_amisha;
    logic [WIDTH-1:0] a_amisha;
    logic [WIDTH-1:0] b_amisha;
    logic             i0_amisha;
    logic             i1_amisha;
    logic             busy_amisha;
    logic             done_amisha;
    logic             eq_amisha;
    logic [CNT_W-1:0] mismatch_cnt_amisha;

    modport master (
        output start_amisha, abort_amisha, a_amisha, b_amisha,
        input  i0_amisha, i1_amisha, busy_amisha, done_amisha, eq_amisha, mismatch_cnt_amisha
    );

    modport slave (
        input  start_amisha, abort_amisha, a_amisha, b_amisha,
        output i0_amisha, i1_amisha, busy_amisha, done_amisha, eq_amisha, mismatch_cnt_amisha
    );
endinterface

// File: rtl/serial_eq_cmp_amisha.sv
// Bit-serial word equality comparator: shifts operands LSB first to a 1-bit stage and counts mismatches.
// Optional macro SERIAL_EQ_EARLY_EXIT_EN ends the scan on the first mismatching bit.
module serial_eq_cmp_amisha #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk_amisha,
    input  logic                  rst_n_amisha,
    serial_eq_cmp_amisha_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             i0;
    logic             i1;
    logic             busy;
    logic             done;
    logic             eq;
    logic             early_exit;

`ifdef SERIAL_EQ_EARLY_EXIT_EN
    // The presented pair is the first mismatch: stop scanning on the next edge.
    assign early_exit = (i0 != i1);
`else
    assign early_exit = 1'b0;
`endif

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            idx   <= '0;
            cnt   <= '0;
            i0    <= 1'b0;
            i1    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            eq    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_amisha && !bus.abort_amisha) begin
                        sh_a  <= bus.a_amisha;
                        sh_b  <= bus.b_amisha;
                        idx   <= '0;
                        cnt   <= '0;
                        eq    <= 1'b0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.abort_amisha) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        i0    <= 1'b0;
                        i1    <= 1'b0;
                        eq    <= 1'b0;
                        cnt   <= '0;
                    end else if (idx == LAST || early_exit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        eq    <= (cnt == '0);
                        i0    <= 1'b0;
                        i1    <= 1'b0;
                    end else begin
                        // Present bit idx and count it in the same cycle it is shown.
                        i0   <= sh_a[0];
                        i1   <= sh_b[0];
                        sh_a <= sh_a >> 1;
                        sh_b <= sh_b >> 1;
                        idx  <= idx + CNT_W'(1);
                        if (sh_a[0] != sh_b[0] && cnt != LAST) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.i0_amisha           = i0;
    assign bus.i1_amisha           = i1;
    assign bus.busy_amisha         = busy;
    assign bus.done_amisha         = done;
    assign bus.eq_amisha           = eq;
    assign bus.mismatch_cnt_amisha = cnt;
endmodule

// File: tb/tb_serial_eq_cmp_amisha.sv
// Directed and randomized checks of serial_eq_cmp_amisha against a word-level reference model.
module tb_serial_eq_cmp_amisha;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    serial_eq_cmp_amisha_if #(.WIDTH(W)) bus ();

    serial_eq_cmp_amisha #(.WIDTH(W)) dut (
        .clk_amisha  (clk),
        .rst_n_amisha(rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word-level expectation: latency from start edge to done, final count and equality.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int cnt, output logic eq);
        logic [W-1:0] x;
        int k;
        x   = a ^ b;
        eq  = (x == '0);
        lat = W + 1;
        cnt = $countones(x);
`ifdef SERIAL_EQ_EARLY_EXIT_EN
        if (x != '0) begin
            k = 0;
            while (x[k] == 1'b0) k++;
            lat = k + 2;
            cnt = 1;
        end
`else
        k = 0;
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy_amisha), 0);
        check({tag, "_done"}, 32'(bus.done_amisha), 0);
        check({tag, "_eq"},   32'(bus.eq_amisha), 0);
        check({tag, "_cnt"},  32'(bus.mismatch_cnt_amisha), 0);
        check({tag, "_i0"},   32'(bus.i0_amisha), 0);
        check({tag, "_i1"},   32'(bus.i1_amisha), 0);
    endtask

    // Caller is between edges; start is sampled on the next rising edge (edge T).
    task automatic run_compare(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit repulse, input int abort_at);
        int   lat, ecnt;
        logic eeq, e0, e1;
        model(a, b, lat, ecnt, eeq);
        bus.a_amisha     = a;
        bus.b_amisha     = b;
        bus.start_amisha = 1'b1;
        @(posedge clk); #1;
        bus.start_amisha = 1'b0;
        bus.a_amisha     = W'($urandom);
        bus.b_amisha     = W'($urandom);
        check($sformatf("%s_busy_c0", name), 32'(bus.busy_amisha), 1);
        for (int j = 1; j <= int'(W) + 3; j++) begin
            @(posedge clk); #1;
            if (abort_at != 0 && j == abort_at) begin
                check_all_zero($sformatf("%s_abort_c%0d", name, j));
                bus.abort_amisha = 1'b0;
                return;
            end
            e0 = (j < lat) ? a[j-1] : 1'b0;
            e1 = (j < lat) ? b[j-1] : 1'b0;
            check($sformatf("%s_i0_c%0d", name, j), 32'(bus.i0_amisha), 32'(e0));
            check($sformatf("%s_i1_c%0d", name, j), 32'(bus.i1_amisha), 32'(e1));
            check($sformatf("%s_done_c%0d", name, j), 32'(bus.done_amisha), 32'(j == lat));
            check($sformatf("%s_busy_c%0d", name, j), 32'(bus.busy_amisha), 32'(j < lat));
            if (j >= lat) begin
                check($sformatf("%s_eq_c%0d", name, j), 32'(bus.eq_amisha), 32'(eeq));
                check($sformatf("%s_cnt_c%0d", name, j), 32'(bus.mismatch_cnt_amisha), 32'(ecnt));
            end
            if (repulse && j == 2) bus.start_amisha = 1'b1;
            if (repulse && j == 3) bus.start_amisha = 1'b0;
            if (abort_at != 0 && j == abort_at - 1) bus.abort_amisha = 1'b1;
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bus.start_amisha = 1'b0;
        bus.abort_amisha = 1'b0;
        bus.a_amisha     = '0;
        bus.b_amisha     = '0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");

        @(negedge clk); rst_n = 1'b1;
        run_compare("a5_a5", 8'hA5, 8'hA5, 1'b0, 0);
        @(negedge clk);
        run_compare("ff_00", 8'hFF, 8'h00, 1'b0, 0);
        @(negedge clk);
        run_compare("01_81", 8'h01, 8'h81, 1'b0, 0);

        @(negedge clk);
        ra = W'($urandom); rb = W'($urandom);
        run_compare("repulse", ra, rb, 1'b1, 0);

        @(negedge clk);
        ra = W'($urandom);
        run_compare("abort", ra, ra, 1'b0, 5);
        run_compare("after_abort", 8'h5A, 8'h5B, 1'b0, 0);

        // Abort wins over a simultaneous start in IDLE.
        @(negedge clk);
        bus.start_amisha = 1'b1;
        bus.abort_amisha = 1'b1;
        @(posedge clk); #1;
        bus.start_amisha = 1'b0;
        bus.abort_amisha = 1'b0;
        check("abort_start_busy", 32'(bus.busy_amisha), 0);
        @(posedge clk); #1;
        check("abort_start_busy2", 32'(bus.busy_amisha), 0);
        check("abort_start_done", 32'(bus.done_amisha), 0);

        for (int n = 0; n < 8; n++) begin
            ra = W'($urandom);
            rb = (n % 2 == 0) ? (ra ^ W'(1 << $urandom_range(W - 1, 0))) : W'($urandom);
            if (n == 6) rb = ra;
            @(negedge clk);
            run_compare($sformatf("rand%0d", n), ra, rb, 1'b0, 0);
        end

        // Asynchronous reset between edges in the middle of a scan.
        @(negedge clk);
        bus.a_amisha     = 8'hF0;
        bus.b_amisha     = 8'h0F;
        bus.start_amisha = 1'b1;
        @(posedge clk); #1 bus.start_amisha = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk); rst_n = 1'b1;
        run_compare("post_rst_3c", 8'h3C, 8'h3C, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
